amber_stg_ia: RTL

- Instruction-address/fetch front end of the amber pipeline. Owns the architectural fetch PC and drives the synchronous instruction memory.
- Presents {PC, instruction, valid} to the decode stage.
- Honours the core-wide stall, branch redirect/flush from the execute stage, and sticky halt from writeback (SRHLT).
- It is the upstream producer for every hazard/forward path in the core.

---
 rtl/amber_stg_ia_if.sv | 28 ++
 rtl/amber_stg_ia.sv | 73 +++++++
 2 files changed

// File: rtl/amber_stg_ia_if.sv
// Fetch-stage bus bundle: pipeline control inputs, instruction-memory port and decode-facing outputs.
// The master modport is the fetch stage; the slave modport is its surroundings (core + memory).
interface amber_stg_ia_if #(
  parameter int unsigned ADDR_WIDTH  = 48,
  parameter int unsigned INSTR_WIDTH = 24
);
  logic                   iw_stall;
  logic                   iw_flush;
  logic [ADDR_WIDTH-1:0]  iw_flush_pc;
  logic                   iw_halt;
  logic [ADDR_WIDTH-1:0]  ow_imem_addr;
  logic                   ow_imem_en;
  logic [INSTR_WIDTH-1:0] iw_imem_data;
  logic [ADDR_WIDTH-1:0]  ow_if_pc;
  logic [INSTR_WIDTH-1:0] ow_if_instr;
  logic                   ow_if_valid;
  logic                   ow_halted;

  modport master (
    input  iw_stall, iw_flush, iw_flush_pc, iw_halt, iw_imem_data,
    output ow_imem_addr, ow_imem_en, ow_if_pc, ow_if_instr, ow_if_valid, ow_halted
  );

  modport slave (
    output iw_stall, iw_flush, iw_flush_pc, iw_halt, iw_imem_data,
    input  ow_imem_addr, ow_imem_en, ow_if_pc, ow_if_instr, ow_if_valid, ow_halted
  );
endinterface

// File: rtl/amber_stg_ia.sv
// Instruction-address / fetch front end: owns the fetch PC, drives the synchronous
// instruction memory and hands {pc, instr, valid} to decode.
module amber_stg_ia #(
  parameter int unsigned           ADDR_WIDTH  = 48,
  parameter int unsigned           INSTR_WIDTH = 24,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0] NOP_WORD   = '0
) (
  input logic            iw_clk,
  input logic            iw_rst_n,
  amber_stg_ia_if.master bus
);

  // BOOT covers the first edge after reset, when memory data is not yet meaningful.
  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]  if_pc_q, if_pc_d;
  logic                   if_valid_q, if_valid_d;

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      if_pc_q    <= RESET_PC;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
    end
  end

  // Priority: halted > halt > flush > stall > advance.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;
    unique case (state_q)
      ST_HALT: if_valid_d = 1'b0;
      default: begin
        if (bus.iw_halt) begin
          state_d    = ST_HALT;
          if_valid_d = 1'b0;
        end else if (bus.iw_flush) begin
          state_d    = ST_RUN;
          pc_d       = bus.iw_flush_pc;
          if_valid_d = 1'b0;
        end else if (bus.iw_stall) begin
          state_d = state_q;
        end else if (state_q == ST_BOOT) begin
          state_d = ST_RUN;
        end else begin
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          pc_d       = pc_q + ADDR_WIDTH'(1);
        end
      end
    endcase
  end

  // Memory output register only advances when enabled, which is what holds instr across a stall.
  assign bus.ow_imem_addr = pc_q;
  assign bus.ow_imem_en   = iw_rst_n & (state_q != ST_HALT) & (bus.iw_flush | ~bus.iw_stall);
  assign bus.ow_if_pc     = if_pc_q;
  assign bus.ow_if_valid  = if_valid_q;
  assign bus.ow_if_instr  = if_valid_q ? bus.iw_imem_data : NOP_WORD;
  assign bus.ow_halted    = (state_q == ST_HALT);

endmodule
